// File: rtl/inst_encoder.sv
// RV32I instruction encoder and program loader: packs decoded instruction fields
// into 32-bit words and streams them into instruction memory at consecutive addresses.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          DEPTH     = 64,
  parameter int          CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          finish,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [6:0]    req_op,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [2:0]    req_f3,
  input  logic          req_f7b5,
  input  logic [20:0]   req_imm,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_cnt,
  output logic          err_pulse,
  output logic [7:0]    err_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [31:0]   next_addr_r;
  logic [CW-1:0] filled_s;
  logic          full_s;
  logic          accept_s;
  logic          start_ok_s;
  logic          legal_s;
  logic [31:0]   word_s;

  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  // Signed 21-bit value fits in a signed 12-bit immediate.
  function automatic logic fits12(input logic [20:0] imm);
    return (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
  endfunction

  function automatic logic imm_legal(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [20:0] imm);
    logic ok;
    case (op)
      OP_LOAD, OP_JALR, OP_STORE: ok = fits12(imm);
      OP_IMM:    ok = is_shift(op, f3) ? (imm[20:5] == 16'h0000) : fits12(imm);
      OP_REG:    ok = 1'b1;
      OP_BRANCH: ok = ((imm[20:12] == 9'h000) || (imm[20:12] == 9'h1FF)) && !imm[0];
      OP_JAL:    ok = !imm[0];
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic f7b5,
                                         input logic [20:0] imm);
    logic [6:0]  f7;
    logic [31:0] w;
    f7 = {1'b0, f7b5, 5'b00000};
    case (op)
      OP_LOAD, OP_JALR: w = {imm[11:0], rs1, f3, rd, op};
      OP_IMM:    w = is_shift(op, f3) ? {f7, imm[4:0], rs1, f3, rd, op}
                                      : {imm[11:0], rs1, f3, rd, op};
      OP_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OP_REG:    w = {f7, rs2, rs1, f3, rd, op};
      OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      OP_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:   w = 32'd0;
    endcase
    return w;
  endfunction

  // Words already committed plus the one being written this cycle.
  assign filled_s   = word_cnt + CW'(imem_we);
  assign full_s     = (filled_s >= DEPTH_W);
  assign accept_s   = req_valid && req_ready;
  assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign legal_s    = imm_legal(req_op, req_f3, req_imm);
  assign word_s     = encode(req_op, req_rd, req_rs1, req_rs2, req_f3, req_f7b5, req_imm);

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a word accepted together with finish drains before DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_RUN;
        else       state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (finish && accept_s && legal_s) state_nxt_s = S_DRAIN;
        else if (finish || full_s)         state_nxt_s = S_DONE;
        else                               state_nxt_s = S_RUN;
      end
      S_DRAIN: state_nxt_s = S_DONE;
      S_DONE: begin
        if (start) state_nxt_s = S_RUN;
        else       state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Status and handshake decode.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_r)
      S_RUN: begin
        req_ready = !full_s;
        busy      = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Write port, address and counters; the accepted word is registered and issued next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we     <= 1'b0;
      imem_addr   <= BASE_ADDR;
      imem_wdata  <= 32'd0;
      next_addr_r <= BASE_ADDR;
      word_cnt    <= '0;
      err_pulse   <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      imem_we   <= 1'b0;
      err_pulse <= 1'b0;
      if (start_ok_s) begin
        next_addr_r <= BASE_ADDR;
        word_cnt    <= '0;
        err_cnt     <= 8'd0;
      end else begin
        if (imem_we) begin
          word_cnt <= word_cnt + CW'(1);
        end
        if (accept_s) begin
          if (legal_s) begin
            imem_we     <= 1'b1;
            imem_addr   <= next_addr_r;
            imem_wdata  <= word_s;
            next_addr_r <= next_addr_r + 32'd4;
          end else begin
            err_pulse <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: encoding vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_inst_encoder;

  localparam logic [31:0] BASE  = 32'd0;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [6:0]    req_op = 7'd0;
  logic [4:0]    req_rd = 5'd0;
  logic [4:0]    req_rs1 = 5'd0;
  logic [4:0]    req_rs2 = 5'd0;
  logic [2:0]    req_f3 = 3'd0;
  logic          req_f7b5 = 1'b0;
  logic [20:0]   req_imm = 21'd0;
  logic          imem_we;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_cnt;
  logic          err_pulse;
  logic [7:0]    err_cnt;

  inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_f3(req_f3),
    .req_f7b5(req_f7b5), .req_imm(req_imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
    .word_cnt(word_cnt), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [20:0] imm;
    bit          ok;
    logic [31:0] word;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Behavioural model: session flags, counts and the expected write port.
  bit          m_open, m_stop, m_done, e_we, e_err;
  int          m_acc, m_words, m_errs;
  logic [31:0] e_addr, e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] u, input int hi, input int lo);
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3, input logic [20:0] imm);
    int v;
    v = $signed(imm);
    case (op)
      7'd3, 7'd35, 7'd103: return (v >= -2048) && (v <= 2047);
      7'd19: begin
        if ((f3 == 3'd1) || (f3 == 3'd5)) return (v >= 0) && (v <= 31);
        else return (v >= -2048) && (v <= 2047);
      end
      7'd51:  return 1'b1;
      7'd99:  return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      7'd111: return (v % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_encode(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic f7b5, input logic [20:0] imm);
    int v;
    logic [31:0] u, bi;
    v = $signed(imm);
    u = v;
    bi = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (op)
      7'd3, 7'd103: return bi | (fld(u, 11, 0) << 20);
      7'd19: begin
        if ((f3 == 3'd1) || (f3 == 3'd5)) return bi | (fld(u, 4, 0) << 20) | (32'(f7b5) << 30);
        else return bi | (fld(u, 11, 0) << 20);
      end
      7'd51: return bi | (32'(rs2) << 20) | (32'(f7b5) << 30);
      7'd35: return 32'(op) | (fld(u, 4, 0) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                    | (32'(rs2) << 20) | (fld(u, 11, 5) << 25);
      7'd99: return 32'(op) | (fld(u, 11, 11) << 7) | (fld(u, 4, 1) << 8) | (32'(f3) << 12)
                    | (32'(rs1) << 15) | (32'(rs2) << 20) | (fld(u, 10, 5) << 25) | (fld(u, 12, 12) << 31);
      7'd111: return 32'(op) | (32'(rd) << 7) | (fld(u, 19, 12) << 12) | (fld(u, 11, 11) << 20)
                     | (fld(u, 10, 1) << 21) | (fld(u, 20, 20) << 31);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_open = 1'b0; m_stop = 1'b0; m_done = 1'b0; e_we = 1'b0; e_err = 1'b0;
    m_acc = 0; m_words = 0; m_errs = 0;
    e_addr = BASE; e_data = 32'd0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc;
    acc = req_valid && m_open && !m_stop && !m_done;
    m_words += int'(e_we);
    e_we = 1'b0;
    e_err = 1'b0;
    if (start && (!m_open || m_done)) begin
      m_open = 1'b1; m_stop = 1'b0; m_done = 1'b0;
      m_acc = 0; m_words = 0; m_errs = 0;
    end else if (m_open && !m_done) begin
      if (acc) begin
        if (m_legal(req_op, req_f3, req_imm)) begin
          e_we = 1'b1;
          e_addr = BASE + 32'(4 * m_acc);
          e_data = m_encode(req_op, req_rd, req_rs1, req_rs2, req_f3, req_f7b5, req_imm);
          m_acc++;
          if (m_acc == DEPTH) m_stop = 1'b1;
        end else begin
          e_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
      end
      if (finish) m_stop = 1'b1;
      if (m_stop && !e_we) m_done = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", imem_addr, e_addr);
    chk("imem_wdata", imem_wdata, e_data);
    chk("req_ready", 32'(req_ready), 32'(m_open && !m_stop && !m_done));
    chk("busy", 32'(busy), 32'(m_open && !m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("word_cnt", 32'(word_cnt), 32'(m_words));
    chk("err_pulse", 32'(err_pulse), 32'(e_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_req(input vec_t v);
    req_op = v.op; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_f3 = v.f3; req_f7b5 = v.f7b5; req_imm = v.imm;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic end_session();
    req_valid = 1'b0;
    finish = 1'b1; cycle(); finish = 1'b0;
    cycle();
  endtask

  vec_t vt[16];
  vec_t st[5];
  int   bnd[12];

  initial begin
    int idx, nwr;
    bit acc;

    // Encoding table: {op, rd, rs1, rs2, f3, f7b5, imm, legal, word}
    vt[0]  = '{7'd19,  5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5,        1'b1, 32'h00500093};
    vt[1]  = '{7'd35,  5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 21'd8,        1'b1, 32'h0020A423};
    vt[2]  = '{7'd51,  5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0,        1'b1, 32'h402081B3};
    vt[3]  = '{7'd99,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h1FFFFC,   1'b1, 32'hFE000EE3};
    vt[4]  = '{7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8,        1'b1, 32'h008000EF};
    vt[5]  = '{7'd19,  5'd5, 5'd6, 5'd0, 3'd5, 1'b1, 21'd3,        1'b1, 32'h40335293};
    vt[6]  = '{7'd3,   5'd7, 5'd8, 5'd0, 3'd2, 1'b0, 21'h1FF800,   1'b1, 32'h80042383};
    vt[7]  = '{7'd103, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0, 21'd0,        1'b1, 32'h00008067};
    vt[8]  = '{7'd99,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h000FFE,   1'b1, 32'h7E000FE3};
    vt[9]  = '{7'd111, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'h100000,   1'b1, 32'h8000006F};
    vt[10] = '{7'd19,  5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048,     1'b0, 32'h0};
    vt[11] = '{7'd99,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd3,        1'b0, 32'h0};
    vt[12] = '{7'd0,   5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd0,        1'b0, 32'h0};
    vt[13] = '{7'd19,  5'd1, 5'd0, 5'd0, 3'd1, 1'b0, 21'd32,       1'b0, 32'h0};
    vt[14] = '{7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd1,        1'b0, 32'h0};
    vt[15] = '{7'd99,  5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 21'd4096,     1'b0, 32'h0};
    st[0] = vt[1]; st[1] = vt[2]; st[2] = vt[3]; st[3] = vt[4]; st[4] = vt[0];
    bnd = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098, 31, 32, -1};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // One request per session from the encoding table
    for (int i = 0; i < 16; i++) begin
      pulse_start();
      set_req(vt[i]);
      req_valid = 1'b1; cycle(); req_valid = 1'b0;
      chk("vec we", 32'(imem_we), 32'(vt[i].ok));
      chk("vec err", 32'(err_pulse), 32'(!vt[i].ok));
      if (vt[i].ok) begin
        chk("vec word", imem_wdata, vt[i].word);
        chk("vec addr", imem_addr, BASE);
      end
      end_session();
    end

    // Back-to-back stream, addresses on consecutive cycles, then full
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      set_req(st[k]);
      req_valid = 1'b1; cycle();
      chk("stream we", 32'(imem_we), 32'd1);
      chk("stream addr", imem_addr, BASE + 32'(4 * k));
      chk("stream word", imem_wdata, st[k].word);
    end
    req_valid = 1'b0; cycle();
    chk("stream done", 32'(done), 32'd1);
    chk("stream word_cnt", 32'(word_cnt), 32'd4);

    // Rejections followed by a valid request at the base address
    pulse_start();
    for (int k = 10; k < 13; k++) begin
      set_req(vt[k]);
      req_valid = 1'b1; cycle();
      chk("reject pulse", 32'(err_pulse), 32'd1);
      chk("reject no write", 32'(imem_we), 32'd0);
    end
    set_req(vt[0]); cycle(); req_valid = 1'b0;
    chk("reject err_cnt", 32'(err_cnt), 32'd3);
    chk("post reject addr", imem_addr, BASE);
    chk("post reject word", imem_wdata, 32'h00500093);
    end_session();

    // Five requests held valid against a four-word session
    pulse_start();
    idx = 0; nwr = 0;
    for (int c = 0; c < 12; c++) begin
      set_req(st[(idx < 5) ? idx : 4]);
      req_valid = 1'b1;
      acc = req_valid && req_ready;
      cycle();
      if (acc) idx++;
      if (imem_we) nwr++;
    end
    req_valid = 1'b0;
    chk("full accepted", 32'(idx), 32'd4);
    chk("full writes", 32'(nwr), 32'd4);
    chk("full done", 32'(done), 32'd1);
    chk("full ready", 32'(req_ready), 32'd0);

    // finish coincident with an acceptance, then restart
    pulse_start();
    set_req(vt[12]); req_valid = 1'b1; cycle();
    set_req(vt[5]); finish = 1'b1; cycle(); finish = 1'b0; req_valid = 1'b0;
    chk("fin write", 32'(imem_we), 32'd1);
    chk("fin not done", 32'(done), 32'd0);
    cycle();
    chk("fin done", 32'(done), 32'd1);
    chk("fin word_cnt", 32'(word_cnt), 32'd1);
    pulse_start();
    chk("restart word_cnt", 32'(word_cnt), 32'd0);
    chk("restart err_cnt", 32'(err_cnt), 32'd0);
    set_req(vt[0]); req_valid = 1'b1; cycle(); req_valid = 1'b0;
    chk("restart addr", imem_addr, BASE);

    // Reset asserted while a write is on the port
    set_req(vt[2]); req_valid = 1'b1; cycle(); req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst we", 32'(imem_we), 32'd0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("rst idle", 32'(busy | done), 32'd0);

    // err_cnt saturation
    pulse_start();
    set_req(vt[12]); req_valid = 1'b1;
    repeat (258) cycle();
    req_valid = 1'b0;
    chk("err_cnt sat", 32'(err_cnt), 32'd255);
    end_session();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      start     = ($urandom_range(0, 11) == 0);
      finish    = ($urandom_range(0, 24) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: req_op = 7'd3;
        1: req_op = 7'd19;
        2: req_op = 7'd35;
        3: req_op = 7'd51;
        4: req_op = 7'd99;
        5: req_op = 7'd103;
        6: req_op = 7'd111;
        default: req_op = 7'($urandom);
      endcase
      req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
      req_f3 = 3'($urandom); req_f7b5 = 1'($urandom);
      case ($urandom_range(0, 3))
        0: req_imm = 21'(int'($urandom_range(0, 80)) - 40);
        1: req_imm = 21'(bnd[$urandom_range(0, 11)]);
        2: req_imm = 21'($urandom);
        default: req_imm = 21'($urandom_range(0, 40));
      endcase
      cycle();
    end
    start = 1'b0;
    end_session();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential RV32I instruction encoder and program loader. It accepts decoded instruction fields (opcode, register indices, funct bits, signed immediate) over a valid/ready handshake and packs them into 32-bit instruction words. It writes those words into instruction memory at consecutive word addresses. It sits in front of the instruction memory during program load and is the encoding counterpart of the main control decoder: it produces exactly the opcodes the decoder consumes (3, 19, 35, 51, 99, 103, 111).

## Interface
Parameters:
- BASE_ADDR, 32'd0, byte address of the first word written after start
- DEPTH, 64, maximum words per load session (≥1)
- CW, $clog2(DEPTH)+1, width of word_cnt

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session (honoured in IDLE or DONE only)
- finish  in  1  one-cycle pulse; ends the session early (honoured in RUN only)
- req_valid  in  1  request fields valid
- req_ready  out  1  encoder can accept; combinational = (state==RUN) && !full
- req_op  in  7  opcode
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_f3  in  3  funct3
- req_f7b5  in  1  funct7 bit 5 (sub/sra/srai)
- req_imm  in  21  signed immediate, byte offset
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state==RUN
- done  out  1  state==DONE
- word_cnt  out  CW  words written this session
- err_pulse  out  1  one-cycle pulse per rejected request
- err_cnt  out  8  rejected requests this session, saturates at 255

## Operation
- FSM states: IDLE → (start) RUN → (finish, or word_cnt reaches DEPTH) DONE → (start) RUN.
- start clears word_cnt and err_cnt and sets the next address to BASE_ADDR.
- Handshake: a request is accepted when req_valid && req_ready. Fields are registered on acceptance. Encode, range check and write occur in the following cycle.
- Encoding by req_op:
  - 3, 103 (I-type): imm[11:0]|rs1|f3|rd|op.
  - 19 (I-type): as above, except when f3 = 001 or 101, bits [31:25] = {0, f7b5, 00000} and bits [24:20] = imm[4:0].
  - 35 (S-type): imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - 51 (R-type): {0, f7b5, 00000}|rs2|rs1|f3|rd|op.
  - 99 (B-type): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - 111 (J-type): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Fields not used by a format are ignored.
- Range rules (req_imm is sign-extended 21-bit):
  - I-type and S-type: value must lie in −2048..2047.
  - B-type: −4096..4094 and imm[0] = 0.
  - J-type: full 21-bit range and imm[0] = 0.
  - Shift immediate (op 19, f3 001/101): 0..31.
- Rejection: an unlisted opcode or a range violation rejects the request.
  - The request is still consumed.
  - No write occurs; address and word_cnt do not advance.
  - err_pulse fires and err_cnt increments.
- Successful write: imem_we = 1 for one cycle, address advances by 4, word_cnt increments by 1.
- Full: when word_cnt reaches DEPTH, req_ready drops in the same cycle the last write issues, and the FSM enters DONE.
- finish in the same cycle as an acceptance: the accepted word is still written in the next cycle, then the FSM goes to DONE. done does not assert until that write completes.
- start outside IDLE/DONE and finish outside RUN are ignored.

## Timing
- Reset (async assert, sync deassert by system):
  - state = IDLE.
  - req_ready, imem_we, busy, done, err_pulse = 0.
  - imem_addr = BASE_ADDR, imem_wdata = 0, word_cnt = 0, err_cnt = 0.
- Latency: acceptance at edge N → imem_we, imem_addr and imem_wdata valid during cycle N+1.
- Throughput: one request per cycle with no bubbles.
- start at edge N → busy and req_ready high from cycle N+1.
- Reset asserted mid-session: any pending write is dropped (imem_we forced low immediately) and the FSM returns to IDLE. No partial state survives.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

## Test plan
- addi x1,x0,5 (op 19, rd 1, rs1 0, f3 0, imm 5) after start → imem_we at BASE_ADDR with wdata 0x00500093; word_cnt = 1.
- Back-to-back stream: sw x2,8(x1) → 0x0020A423; sub x3,x1,x2 (f7b5 = 1) → 0x402081B3; beq x0,x0,−4 → 0xFE000EE3; jal x1,8 → 0x008000EF. Required: addresses 0, 4, 8, 12 on consecutive cycles.
- Rejection: addi with imm 2048, then beq with imm 3, then op 7'd0 → three err_pulses, err_cnt = 3, no imem_we, next valid request still written at BASE_ADDR.
- Full: DEPTH = 4 with five requests held valid → exactly 4 writes, req_ready low after the 4th acceptance, done = 1, 5th request never accepted.
- finish coincident with acceptance → that word is written, then done = 1. A following start restarts at BASE_ADDR with word_cnt = 0 and err_cnt = 0.
- rst_n pulsed low in the cycle after an acceptance → no imem_we, all outputs at reset values immediately, FSM in IDLE.
